// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and constants for the 4-requester round-robin data arbiter.
// Holds the FSM state enum, sizing constants and the rotating priority pick.
package mux_rr_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {IDLE, GRANT} state_t;

  // Walk from last_ptr+4 down to last_ptr+1 so the nearest requester after last_ptr wins.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [SEL_W-1:0]   last_ptr);
    logic [SEL_W-1:0] idx;
    rr_pick = last_ptr;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = last_ptr + SEL_W'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_mux4_1.sv
// Plain 4:1 single-bit multiplexer; {s1,s0} selects d0..d3 onto y.
module mux4_1 (
  input  logic d0,
  input  logic d1,
  input  logic d2,
  input  logic d3,
  input  logic s0,
  input  logic s1,
  output logic y
);

  always_comb begin
    case ({s1, s0})
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      default: y = d3;
    endcase
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter with per-holder burst limit steering four data bits
// onto one shared output through a registered select.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               d0,
  input  logic               d1,
  input  logic               d2,
  input  logic               d3,
  output logic [NUM_REQ-1:0] gnt,
  output logic               s1,
  output logic               s0,
  output logic               y,
  output logic               y_valid
);

  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  state_t           state;
  logic [3:0]       burst_cnt;
  logic [SEL_W-1:0] last_ptr;
  logic [SEL_W-1:0] sel;
  logic [SEL_W-1:0] winner;
  logic             any_req;
  logic             rel;
  logic             take;
  logic             drop;

  assign {s1, s0} = sel;

  // The holder is always last_ptr, so a release re-arbitration naturally ranks it last.
  always_comb begin
    winner  = rr_pick(req, last_ptr);
    any_req = |req;
    rel     = (state == GRANT) && (!req[sel] || (burst_cnt == BURST_LAST));
    take    = ((state == IDLE) || rel) && any_req;
    drop    = rel && !any_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      sel       <= '0;
      y_valid   <= 1'b0;
      burst_cnt <= '0;
      last_ptr  <= SEL_W'(NUM_REQ - 1);
    end else if (take) begin
      state     <= GRANT;
      gnt       <= NUM_REQ'(1) << winner;
      sel       <= winner;
      y_valid   <= 1'b1;
      burst_cnt <= '0;
      last_ptr  <= winner;
    end else if (drop) begin
      state     <= IDLE;
      gnt       <= '0;
      y_valid   <= 1'b0;
      burst_cnt <= '0;
    end else if (state == GRANT) begin
      burst_cnt <= burst_cnt + 4'd1;
    end
  end

  mux4_1 u_mux (
    .d0 (d0),
    .d1 (d1),
    .d2 (d2),
    .d3 (d3),
    .s0 (s0),
    .s1 (s1),
    .y  (y)
  );

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed scoreboard bench for mux_rr_arbiter (MAX_BURST = 4).
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] dvec;
  logic [3:0] gnt;
  logic       s1, s0, y, y_valid;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       vld;
    int         cnt;
    string      tag;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  mux_rr_arbiter #(.MAX_BURST(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .d0      (dvec[0]),
    .d1      (dvec[1]),
    .d2      (dvec[2]),
    .d3      (dvec[3]),
    .gnt     (gnt),
    .s1      (s1),
    .s0      (s0),
    .y       (y),
    .y_valid (y_valid)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Drive req before an edge, queue the expectation, then compare after the edge.
  task automatic step(input logic [3:0] r, input logic [3:0] g, input logic [1:0] s,
                      input logic v, input int c, input string tag);
    exp_t e;
    @(negedge clk);
    req   = r;
    e.gnt = g;
    e.sel = s;
    e.vld = v;
    e.cnt = c;
    e.tag = tag;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    check({e.tag, "_gnt"}, 8'(gnt), 8'(e.gnt));
    check({e.tag, "_sel"}, 8'({s1, s0}), 8'(e.sel));
    check({e.tag, "_vld"}, 8'(y_valid), 8'(e.vld));
    check({e.tag, "_y"}, 8'(y), 8'(dvec[e.sel]));
    if (e.cnt >= 0) check({e.tag, "_cnt"}, 8'(dut.burst_cnt), 8'(e.cnt));
  endtask

  task automatic dcheck(input logic [3:0] dv, input logic exp_y, input string tag);
    dvec = dv;
    #1;
    check(tag, 8'(y), 8'(exp_y));
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b1111;
    dvec  = 4'b0110;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", 8'(gnt), 8'h00);
    check("rst_sel", 8'({s1, s0}), 8'h00);
    check("rst_vld", 8'(y_valid), 8'h00);
    check("rst_last", 8'(dut.last_ptr), 8'h03);
    check("rst_cnt", 8'(dut.burst_cnt), 8'h00);
    #2 rst_n = 1'b1;

    // Full rotation with everyone requesting
    for (int g = 0; g < 4; g++)
      for (int c = 0; c < 4; c++)
        step(4'b1111, 4'(1 << g), 2'(g), 1'b1, c, $sformatf("rot%0d_%0d", g, c));
    step(4'b1111, 4'b0001, 2'd0, 1'b1, 0, "rot_wrap");

    // Idle with held select, then early release of holder 2
    step(4'b0000, 4'b0000, 2'd0, 1'b0, -1, "idle");
    step(4'b0100, 4'b0100, 2'd2, 1'b1, 0, "early0");
    step(4'b0100, 4'b0100, 2'd2, 1'b1, 1, "early1");
    step(4'b0001, 4'b0001, 2'd0, 1'b1, 0, "early_rel");

    // Sole requester re-wins after each burst
    for (int i = 0; i < 10; i++)
      step(4'b0100, 4'b0100, 2'd2, 1'b1, i % 4, $sformatf("sole%0d", i));

    // Data path while requester 3 holds
    step(4'b1000, 4'b1000, 2'd3, 1'b1, 0, "dp_gnt");
    dcheck(4'b0111, 1'b0, "dp_d3lo");
    dcheck(4'b1000, 1'b1, "dp_d3hi");
    dcheck(4'b0000, 1'b0, "dp_d3lo2");

    // Asynchronous reset in the middle of a grant
    dvec = 4'b1001;
    step(4'b0010, 4'b0010, 2'd1, 1'b1, 0, "pre_rst");
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_gnt", 8'(gnt), 8'h00);
    check("mid_rst_vld", 8'(y_valid), 8'h00);
    check("mid_rst_sel", 8'({s1, s0}), 8'h00);
    check("mid_rst_last", 8'(dut.last_ptr), 8'h03);
    check("mid_rst_y", 8'(y), 8'h01);
    #1 rst_n = 1'b1;
    step(4'b0010, 4'b0010, 2'd1, 1'b1, 0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
